// File: rtl/and_bbb.sv
// Single-bit AND primitive from the bool/bool/bool library: y = a & b.
// Purely combinational; clock and reset exist only for a uniform primitive interface.
module and_bbb (
  input  logic clock,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic y
);

  // Clock and reset are intentionally left out of the data path.
  logic unused_ports;
  assign unused_ports = clock ^ reset;

  // Zero-latency AND; any change on a or b reaches y without a clock edge.
  assign y = a & b;

endmodule

// File: tb/tb_and_bbb.sv
// Self-checking bench for and_bbb: directed truth-table and reset cases, then
// randomized operands and reset checked against a behavioural AND model.
module tb_and_bbb;

  logic clock;
  logic reset;
  logic a;
  logic b;
  logic y;

  int compared;
  int mismatched;

  and_bbb dut (
    .clock(clock),
    .reset(reset),
    .a    (a),
    .b    (b),
    .y    (y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Logical AND from its definition: true only when both operands are true.
  function automatic logic model_and(input logic op_a, input logic op_b);
    int ones;
    ones = int'(op_a) + int'(op_b);
    return (ones == 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    compared = compared + 1;
    if (observed !== expected) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: observed y=%b expected y=%b (a=%b b=%b reset=%b)",
               tag, observed, expected, a, b, reset);
    end
  endtask

  // Apply operands just after a rising edge, check immediately (no clock
  // edge in between), then again just before the next rising edge.
  task automatic apply_and_check(input string tag, input logic va, input logic vb,
                                 input logic vr);
    @(posedge clock);
    #1;
    a     = va;
    b     = vb;
    reset = vr;
    #1;
    check_bit({tag, "_comb"}, y, model_and(va, vb));
    #2;
    check_bit({tag, "_mid"}, y, model_and(va, vb));
    @(negedge clock);
    #4;
    check_bit({tag, "_pre_edge"}, y, model_and(va, vb));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    a          = 1'b0;
    b          = 1'b0;
    reset      = 1'b1;

    // Reset with both operands low: y low during reset and after release.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_bit("reset_hold_00", y, 1'b0);
    apply_and_check("post_reset_00", 1'b0, 1'b0, 1'b0);

    apply_and_check("a1_b0", 1'b1, 1'b0, 1'b0);
    apply_and_check("a0_b1", 1'b0, 1'b1, 1'b0);
    apply_and_check("a1_b1_zero_latency", 1'b1, 1'b1, 1'b0);

    // Reset asserted with both operands high must not disturb y.
    apply_and_check("reset_a1_b1", 1'b1, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    check_bit("reset_a1_b1_after_edge", y, 1'b1);
    apply_and_check("reset_release_a1_b1", 1'b1, 1'b1, 1'b0);
    apply_and_check("reset_a1_b0", 1'b1, 1'b0, 1'b1);
    apply_and_check("reset_a0_b1", 1'b0, 1'b1, 1'b1);

    // Randomized operands and reset, including changes twice per cycle.
    for (int i = 0; i < 200; i++) begin
      logic ra;
      logic rb;
      logic rr;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 3) == 0);
      apply_and_check("random", ra, rb, rr);
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      a  = ra;
      b  = rb;
      #1;
      check_bit("random_between_edges", y, model_and(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
